// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage skid register.
// Contents:
//   pipe_state_t     - stage occupancy state (EMPTY / FULL / SKID; 2'd3 is illegal)
//   F_D_W, D_E_W     - payload widths of the concatenated stage field bundles
//   state_in_ready   - in_ready implied by a state
//   state_out_valid  - out_valid implied by a state
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int F_D_W = 64;
  localparam int D_E_W = 143;

  // Only the two-entry state refuses new input.
  function automatic logic state_in_ready(input pipe_state_t st);
    logic rdy;
    case (st)
      EMPTY:   rdy = 1'b1;
      FULL:    rdy = 1'b1;
      SKID:    rdy = 1'b0;
      default: rdy = 1'b1;
    endcase
    return rdy;
  endfunction

  // Any occupied state presents its head payload.
  function automatic logic state_out_valid(input pipe_state_t st);
    logic vld;
    case (st)
      EMPTY:   vld = 1'b0;
      FULL:    vld = 1'b1;
      SKID:    vld = 1'b1;
      default: vld = 1'b0;
    endcase
    return vld;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline stage: upstream side (in_*) and
// downstream side (out_*).
// Modports:
//   slave  - the stage itself: consumes in_valid/in_data/out_ready,
//            drives in_ready/out_valid/out_data
//   master - the surrounding pipeline (or a bench) driving the stage
interface pipe_stage_skid_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_en_reg.sv
// Enable register with a parameterised reset value.
// Ports: clk, rst (async, active-high), en (write enable), d (next value),
//        q (registered value).
module pipe_en_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  assign q = q_r;

  // Storage: load d only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Occupancy FSM and datapath enable decode for the skid stage.
// Ports: clk, rst (async, active-high), in_valid, out_ready, flush (inputs);
//        in_ready, out_valid (registered), main_we, skid_we, main_sel_skid
//        (combinational enables for the two data registers).
module pipe_stage_ctrl
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  input  logic flush,
  output logic in_ready,
  output logic out_valid,
  output logic main_we,
  output logic skid_we,
  output logic main_sel_skid
);

  pipe_state_t state_r;
  pipe_state_t state_nxt_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        in_fire_s;
  logic        out_fire_s;
  logic        main_we_s;
  logic        skid_we_s;
  logic        main_sel_skid_s;

  // Handshakes use only registered flags, so in_ready never sees out_ready.
  assign in_fire_s     = in_valid & in_ready_r;
  assign out_fire_s    = out_valid_r & out_ready;
  assign in_ready      = in_ready_r;
  assign out_valid     = out_valid_r;
  assign main_we       = main_we_s;
  assign skid_we       = skid_we_s;
  assign main_sel_skid = main_sel_skid_s;

  // Next-state and enable decode; flush overrides everything and writes nothing.
  always_comb begin
    state_nxt_s     = state_r;
    main_we_s       = 1'b0;
    skid_we_s       = 1'b0;
    main_sel_skid_s = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_we_s   = 1'b1;
            state_nxt_s = FULL;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        FULL: begin
          if (in_fire_s && out_fire_s) begin
            main_we_s   = 1'b1;
            state_nxt_s = FULL;
          end else if (in_fire_s) begin
            skid_we_s   = 1'b1;
            state_nxt_s = SKID;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = FULL;
          end
        end
        SKID: begin
          if (out_fire_s) begin
            main_we_s       = 1'b1;
            main_sel_skid_s = 1'b1;
            state_nxt_s     = FULL;
          end else begin
            state_nxt_s = SKID;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // State register with handshake flags registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= state_in_ready(state_nxt_s);
      out_valid_r <= state_out_valid(state_nxt_s);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a 2-entry skid buffer, synchronous
// flush and a saturating back-pressure counter.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   bus       - pipe_stage_skid_if.slave: in_valid/in_ready/in_data upstream,
//               out_valid/out_ready/out_data downstream
//   flush     - synchronous squash of all held payloads
//   stall_cnt - cycles with out_valid=1 and out_ready=0, saturating
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stage_skid_if.slave   bus,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic             main_we_s;
  logic             skid_we_s;
  logic             main_sel_skid_s;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] main_q_s;
  logic [WIDTH-1:0] skid_q_s;
  logic [CNT_W-1:0] stall_cnt_r;

  pipe_stage_ctrl u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (bus.in_valid),
    .out_ready     (bus.out_ready),
    .flush         (flush),
    .in_ready      (bus.in_ready),
    .out_valid     (bus.out_valid),
    .main_we       (main_we_s),
    .skid_we       (skid_we_s),
    .main_sel_skid (main_sel_skid_s)
  );

  // Main register refills from the skid entry when draining two-deep.
  always_comb begin
    if (main_sel_skid_s) begin
      main_d_s = skid_q_s;
    end else begin
      main_d_s = bus.in_data;
    end
  end

  pipe_en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main_reg (
    .clk (clk),
    .rst (rst),
    .en  (main_we_s),
    .d   (main_d_s),
    .q   (main_q_s)
  );

  pipe_en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_we_s),
    .d   (bus.in_data),
    .q   (skid_q_s)
  );

  assign bus.out_data = main_q_s;
  assign stall_cnt    = stall_cnt_r;

  // Back-pressure counter; only reset clears it, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. The reference model treats the
// stage as a FIFO of at most two payloads plus the last head value.
module tb_pipe_stage_skid;

  localparam logic [31:0] RST_V = 32'h8000_0000;
  localparam int          CMAX  = 15;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] stall_cnt;

  pipe_stage_skid_if #(.WIDTH(32)) bus ();

  pipe_stage_skid #(.WIDTH(32), .RESET_VAL(RST_V), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] mq[$];
  logic [31:0] m_main;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_main = RST_V;
    m_cnt  = 0;
  endtask

  // Entered at a negedge: drive inputs, check outputs, advance one clock.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic in_f;
    logic out_f;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    check_eq("in_ready",  {63'd0, bus.in_ready},  {63'd0, (mq.size() < 2)});
    check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, (mq.size() > 0)});
    check_eq("out_data",  {32'd0, bus.out_data},  {32'd0, m_main});
    check_eq("stall_cnt", {60'd0, stall_cnt},     64'(m_cnt));
    in_f  = iv && (mq.size() < 2);
    out_f = (mq.size() > 0) && ordy;
    @(posedge clk);
    if ((mq.size() > 0) && !ordy && (m_cnt < CMAX)) m_cnt++;
    if (fl) begin
      mq.delete();
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(d);
    end
    if (mq.size() > 0) m_main = mq[0];
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and streaming at one payload per cycle.
    cycle(1'b1, 32'd1, 1'b1, 1'b0);
    cycle(1'b1, 32'd2, 1'b1, 1'b0);
    cycle(1'b1, 32'd3, 1'b1, 1'b0);
    cycle(1'b1, 32'd4, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // Skid fill and drain.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    #1;
    check_eq("skid_head",  {32'd0, bus.out_data}, {32'd0, 32'hA});
    check_eq("skid_ready", {63'd0, bus.in_ready}, 64'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // Back-pressure saturation, unaffected by flush.
    cycle(1'b1, 32'h7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    check_eq("stall_sat", {60'd0, stall_cnt}, 64'd15);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    #1;
    check_eq("stall_after_flush", {60'd0, stall_cnt}, 64'd15);

    // Flush while two-deep with a simultaneous push.
    cycle(1'b1, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 32'h2, 1'b0, 1'b0);
    cycle(1'b1, 32'h3, 1'b0, 1'b1);
    #1;
    check_eq("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("flush_ready", {63'd0, bus.in_ready},  64'd1);
    cycle(1'b1, 32'h4, 1'b1, 1'b0);
    #1;
    check_eq("post_flush_data", {32'd0, bus.out_data}, {32'd0, 32'h4});
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("arst_data",  {32'd0, bus.out_data},  {32'd0, RST_V});
    check_eq("arst_ready", {63'd0, bus.in_ready},  64'd1);
    check_eq("arst_cnt",   {60'd0, stall_cnt},     64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random soak against the queue model.
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic pipeline-stage data register that replaces the fixed-field, enable-only inter-stage buffers.
- Carries a WIDTH-bit payload between any two pipeline stages (F/D, D/E, E/M, M/W) with a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready free of any combinational path from out_ready.
- Adds synchronous flush (branch/trap squash) and a saturating back-pressure counter for performance debug.

Parameters:
- WIDTH, 32, payload width in bits (min 1). Callers concatenate stage fields.
- RESET_VAL, 0, value loaded into both data registers on reset (M/W PC uses 32'h8000_0000).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; function of state register only.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  head payload, driven directly from the main register.
- flush  input  1  synchronous squash of all held payloads.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_data is sampled only on in_fire. out_data must stay stable while out_valid=1 and out_ready=0.
- Storage: main register holds the head payload; skid register holds the second payload. Each register has its own write enable.
- Reset (asynchronous): state=EMPTY, main=skid=RESET_VAL, stall_cnt=0. After reset: out_valid=0, in_ready=1.
- State outputs: EMPTY gives in_ready=1, out_valid=0. FULL gives in_ready=1, out_valid=1. SKID gives in_ready=0, out_valid=1.
- Transitions from EMPTY:
  - in_fire: load main <- in_data, go to FULL.
  - otherwise: stay in EMPTY.
- Transitions from FULL:
  - in_fire & out_fire: main <- in_data, stay in FULL (one transfer per cycle, zero bubbles).
  - in_fire & !out_ready: skid <- in_data, go to SKID.
  - !in_fire & out_fire: go to EMPTY.
  - otherwise: hold.
- Transitions from SKID:
  - out_fire: main <- skid, go to FULL. No input is accepted in this state.
  - otherwise: hold, with both registers unchanged.
- Latency and ordering: in_fire in cycle N makes the payload visible on out_data in cycle N+1 when the stage was EMPTY, or N+1 when FULL with out_fire. Payloads leave in arrival order with no loss or duplication.
- Flush has the highest priority.
  - Next state is EMPTY.
  - A payload presented with in_fire in the same cycle is dropped.
  - Data registers are not written, so out_data keeps its stale value with out_valid=0.
  - in_ready is 1 in the cycle after the flush.
- stall_cnt: increments each cycle with out_valid & !out_ready; holds at 2^CNT_W-1. Flush does not clear it; only rst does.
- Reset asserted mid-transfer: immediate return to reset values. Any held payloads are lost by design.
- Throughput: sustains 1 payload/cycle when out_ready is held at 1.

Decomposition:
- Shared package pipe_pkg:
  - typedef pipe_state_t with EMPTY=2'd0, FULL=2'd1, SKID=2'd2. The encoding 2'd3 is illegal and recovers to EMPTY.
  - Fan-in constants for stage field bundles (e.g., F_D_W=64, D_E_W=143).
- Sub-module pipe_stage_ctrl: the FSM plus the enable decode (main_we, skid_we, main_sel_skid). Datapath registers are instantiated from the existing enable register with a reset-value parameter.

Test Plan:
- Reset, then streaming: rst pulse, then drive in_valid=1 with out_ready=1 and data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles one cycle later; in_ready=1 throughout; stall_cnt=0.
- Skid fill: FULL holding 0xA, out_ready=0, push 0xB -> state SKID, in_ready=0, out_data=0xA. Raise out_ready -> outputs 0xA then 0xB, and in_ready returns to 1 after the first pop.
- Back-pressure count: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Asserting flush -> stall_cnt still 15.
- Flush with simultaneous push: SKID holding 0x1 and 0x2, flush=1 and in_valid=1 with 0x3 -> next cycle out_valid=0, in_ready=1. A later push of 0x4 -> out_data=0x4; 0x1, 0x2 and 0x3 never appear.
- Reset value and async reset: RESET_VAL=32'h8000_0000, assert rst between clock edges while FULL -> out_valid=0 and out_data=32'h8000_0000 before the next edge.
- Random soak: random in_valid/out_ready/flush for 10k cycles against a scoreboard queue -> in-order delivery, no drops except flushed payloads, no change on out_data while stalled.
